irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Parametrised multi-channel interrupt controller that replaces the single `interrupt` line into the program sequencer. It latches up to NUM_IRQ sources (per-channel edge or level mode), applies a PS-writable enable mask, and selects the highest-priority source. It presents a vector address and request to the PS via a req/ack handshake, and tracks nested service levels with a priority stack popped on return-from-interrupt.

## Interface
- NUM_IRQ, 8, number of interrupt channels; channel 0 has highest priority
- EDGE_MASK, {NUM_IRQ{1'b1}}, bit i = 1: channel i rising-edge triggered; 0: level triggered
- VEC_WIDTH, 16, vector width (matches PMA_SIZE)
- VEC_BASE, 16'h0010, vector of channel 0
- VEC_STRIDE, 4, vector spacing between channels
- NEST_DEPTH, 4, maximum nested service levels
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- irq_in  in  NUM_IRQ  raw interrupt sources, synchronous to clk
- ps_ic_mask_wr  in  1  write enable for mask register
- ps_ic_mask_dt  in  NUM_IRQ  mask data; bit = 1 enables channel
- ps_ic_ack  in  1  PS accepts current request
- ps_ic_rti  in  1  PS returns from current service level
- ic_ps_req  out  1  interrupt request to PS
- ic_ps_vec  out  VEC_WIDTH  vector of requested channel, valid while ic_ps_req
- ic_ps_lvl  out  $clog2(NEST_DEPTH+1)  current nesting depth
- ic_ps_err  out  1  sticky error: rti with empty stack

## Operation
- Reset values:
  - mask = 0 (all channels disabled); pending = 0; irq_q = 0; stack empty; state IDLE
  - outputs: ic_ps_req = 0, ic_ps_vec = 0, ic_ps_lvl = 0, ic_ps_err = 0
- Pending:
  - Edge channel: pending set on irq_in & ~irq_q; cleared only when that channel is acked. A set on the same edge as the clear wins.
  - Level channel: pending = registered irq_in; never cleared by ack.
- Eligibility:
  - eligible = pending & mask & prio_ok.
  - prio_ok[i] is 1 when the stack is empty, or when i < top-of-stack channel (strict preemption).
  - All channels are ineligible while lvl == NEST_DEPTH.
- Masked channels still latch pending.
- Mask write takes effect on the following edge.
- FSM IDLE:
  - If any channel is eligible: register winner = lowest eligible index; ic_ps_vec = VEC_BASE + winner*VEC_STRIDE, truncated to VEC_WIDTH; ic_ps_req = 1; go to REQ.
- FSM REQ:
  - ic_ps_vec is frozen. A later higher-priority arrival does not change it.
  - On ps_ic_ack: push winner; lvl += 1; clear the edge pending bit; ic_ps_req = 0; go to IDLE.
  - Withdraw: if the winner is no longer eligible (level source dropped, or masked) and there is no ack in that cycle, ic_ps_req = 0 and go to IDLE without a push.
- ps_ic_rti:
  - Stack non-empty: pop; lvl -= 1.
  - Stack empty: ignored; ic_ps_err set (cleared only by reset).
- ps_ic_ack in IDLE is ignored.
- ack and rti in the same cycle: pop first, then push. lvl is unchanged and the top is replaced by the acked channel.
- rti while in REQ: pop happens; the pending request stays frozen.

## Timing
- irq_in rises before edge k → pending at edge k → ic_ps_req and ic_ps_vec valid after edge k+1. Latency is 2 cycles from irq_in assertion.
- ack sampled at edge m → ic_ps_req low after edge m. Earliest next request is after edge m+1 (one mandatory IDLE cycle).
- ic_ps_lvl updates on the same edge as ack/rti.
- Mask write at edge k → eligibility uses the new mask from edge k+1.
- Reset asserted mid-request: all outputs return to reset values at that edge. Pending and stack contents are lost.

## Structure
- Package `ic_pkg`:
  - state enum (IC_IDLE, IC_REQ)
  - function `ic_vec(idx)` computing base + idx*stride
  - localparam for lvl width
- Sub-module `ic_prio_enc`: combinational lowest-index-first encoder over NUM_IRQ, with `any` and `idx` outputs.
- Top level `irq_ctrl` contains:
  - pending and mask registers
  - irq_q edge register
  - priority stack (NEST_DEPTH × $clog2(NUM_IRQ) bits plus depth counter)
  - FSM

## Test plan
- Reset, write mask = 8'hFF, pulse irq_in[3] one cycle → req after 2 cycles, vec = 16'h001C; ack → req low, lvl = 1.
- With ch3 in service, raise irq_in[5] and irq_in[1] together → req with vec = 16'h0014 (ch1); ch5 is not requested until two rti.
- Level ch2 (EDGE_MASK bit 2 = 0) asserted, then dropped while in REQ before ack → req low next cycle, lvl unchanged, no vector for ch2.
- NEST_DEPTH = 4: nest ch7, ch6, ch5, ch4, then raise ch0 → no req until an rti; then vec = 16'h0010.
- rti with lvl = 0 → ic_ps_err = 1 and stays 1; ack and rti in the same cycle with lvl = 2 → lvl stays 2.
- Edge on ch4 while masked → no req; enable mask bit 4 → req 1 cycle later with vec = 16'h0020.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, vector
// arithmetic and nesting-level width helpers.
package ic_pkg;

  typedef logic [0:0] ic_state_t;

  localparam ic_state_t IC_IDLE = 1'b0;
  localparam ic_state_t IC_REQ  = 1'b1;

  localparam int IC_NEST_DEPTH_DFLT = 4;
  localparam int IC_LVL_W           = $clog2(IC_NEST_DEPTH_DFLT + 1);

  // Vector address of a channel; callers truncate to their vector width.
  function automatic int unsigned ic_vec(input int unsigned idx,
                                         input int unsigned base,
                                         input int unsigned stride);
    return base + idx * stride;
  endfunction

  function automatic int ic_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ic_prio_enc.sv
// Lowest-index-first priority encoder; channel 0 has the highest priority.
module ic_prio_enc #(
  parameter int N = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-channel interrupt controller: latches edge/level sources, masks them,
// requests the best eligible channel from the PS and tracks nested service.
module irq_ctrl
  import ic_pkg::*;
#(
  parameter int                   NUM_IRQ    = 8,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = {NUM_IRQ{1'b1}},
  parameter int                   VEC_WIDTH  = 16,
  parameter logic [VEC_WIDTH-1:0] VEC_BASE   = 16'h0010,
  parameter int                   VEC_STRIDE = 4,
  parameter int                   NEST_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_IRQ-1:0]                irq_in,
  input  logic                              ps_ic_mask_wr,
  input  logic [NUM_IRQ-1:0]                ps_ic_mask_dt,
  input  logic                              ps_ic_ack,
  input  logic                              ps_ic_rti,
  output logic                              ic_ps_req,
  output logic [VEC_WIDTH-1:0]              ic_ps_vec,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   ic_ps_lvl,
  output logic                              ic_ps_err,
  output ic_state_t                         dbg_state
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int LVL_W = ic_lvl_w(NEST_DEPTH);

  // Handshake: ic_ps_req stays high with a frozen ic_ps_vec until the PS
  // samples ps_ic_ack high on a clock edge, or the request is withdrawn
  // because its channel stopped being eligible; ack while idle is ignored.

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [IDX_W-1:0]   stk [NEST_DEPTH];
  logic [LVL_W-1:0]   lvl;
  ic_state_t          state;
  logic [IDX_W-1:0]   winner;
  logic [VEC_WIDTH-1:0] vec;
  logic               err;

  logic [IDX_W-1:0]   top_ch;
  logic [NUM_IRQ-1:0] prio_ok;
  logic [NUM_IRQ-1:0] eligible;
  logic               elig_any;
  logic [IDX_W-1:0]   elig_idx;
  logic               ack_take;
  logic               pop;
  logic [LVL_W-1:0]   lvl_pop;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pend_nxt;

  always_comb begin
    top_ch = '0;
    for (int j = 0; j < NEST_DEPTH; j++) begin
      if (lvl == LVL_W'(j + 1)) top_ch = stk[j];
    end
  end

  // Only strictly higher-priority channels may preempt the one in service.
  always_comb begin
    prio_ok = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      prio_ok[i] = (lvl == '0) || (IDX_W'(i) < top_ch);
    end
    if (lvl == LVL_W'(NEST_DEPTH)) prio_ok = '0;
  end

  assign eligible = pending & mask & prio_ok;

  ic_prio_enc #(.N(NUM_IRQ)) u_enc (
    .req (eligible),
    .any (elig_any),
    .idx (elig_idx)
  );

  assign ack_take = (state == IC_REQ) && ps_ic_ack;
  assign pop      = ps_ic_rti && (lvl != '0);
  assign lvl_pop  = lvl - LVL_W'(pop);
  assign clr      = ack_take ? ((NUM_IRQ'(1) << winner) & EDGE_MASK) : '0;

  // A new edge in the same cycle as its ack re-arms the channel.
  assign pend_nxt = (((pending & ~clr) | (irq_in & ~irq_q)) & EDGE_MASK)
                  | (irq_in & ~EDGE_MASK);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
      lvl     <= '0;
      state   <= IC_IDLE;
      winner  <= '0;
      vec     <= '0;
      err     <= 1'b0;
      for (int j = 0; j < NEST_DEPTH; j++) stk[j] <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= pend_nxt;
      if (ps_ic_mask_wr) mask <= ps_ic_mask_dt;
      if (ps_ic_rti && (lvl == '0)) err <= 1'b1;

      // Pop before push, so ack+rti replaces the top entry.
      lvl <= lvl_pop + LVL_W'(ack_take);
      for (int j = 0; j < NEST_DEPTH; j++) begin
        if (ack_take && (lvl_pop == LVL_W'(j))) stk[j] <= winner;
      end

      case (state)
        IC_IDLE: begin
          if (elig_any) begin
            state  <= IC_REQ;
            winner <= elig_idx;
            vec    <= VEC_WIDTH'(ic_vec(int'(elig_idx), int'(VEC_BASE),
                                        VEC_STRIDE));
          end
        end
        default: begin
          if (ack_take || !eligible[winner]) state <= IC_IDLE;
        end
      endcase
    end
  end

  assign ic_ps_req = (state == IC_REQ);
  assign ic_ps_vec = vec;
  assign ic_ps_lvl = lvl;
  assign ic_ps_err = err;
  assign dbg_state = state;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, every cycle
// compared with a queue-based behavioural model of the controller.
module tb_irq_ctrl;
  import ic_pkg::*;

  localparam int         N    = 8;
  localparam logic [7:0] EM   = 8'hFB;
  localparam int         ND   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       ps_ic_mask_wr;
  logic [7:0] ps_ic_mask_dt;
  logic       ps_ic_ack;
  logic       ps_ic_rti;
  logic       ic_ps_req;
  logic [15:0] ic_ps_vec;
  logic [2:0] ic_ps_lvl;
  logic       ic_ps_err;
  ic_state_t  dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  bit [7:0]  m_irq_q, m_pend, m_mask;
  int        m_stk[$];
  bit        m_req, m_err;
  int        m_win;
  bit [15:0] m_vec;

  always #5 clk = ~clk;

  irq_ctrl #(
    .NUM_IRQ(N), .EDGE_MASK(EM), .VEC_WIDTH(16), .VEC_BASE(16'h0010),
    .VEC_STRIDE(4), .NEST_DEPTH(ND)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in),
    .ps_ic_mask_wr(ps_ic_mask_wr), .ps_ic_mask_dt(ps_ic_mask_dt),
    .ps_ic_ack(ps_ic_ack), .ps_ic_rti(ps_ic_rti),
    .ic_ps_req(ic_ps_req), .ic_ps_vec(ic_ps_vec), .ic_ps_lvl(ic_ps_lvl),
    .ic_ps_err(ic_ps_err), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic bit m_elig(input int i);
    if (m_stk.size() >= ND) return 1'b0;
    if (!(m_pend[i] && m_mask[i])) return 1'b0;
    if (m_stk.size() == 0) return 1'b1;
    return i < m_stk[m_stk.size()-1];
  endfunction

  task automatic model_update();
    bit [7:0] el;
    bit       ack_eff;
    int       pick;
    if (reset) begin
      m_irq_q = '0; m_pend = '0; m_mask = '0; m_stk.delete();
      m_req = 0; m_err = 0; m_win = 0; m_vec = '0;
      return;
    end
    for (int i = 0; i < N; i++) el[i] = m_elig(i);
    ack_eff = ps_ic_ack && m_req;
    if (ps_ic_rti) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_err = 1;
    end
    if (ack_eff) m_stk.push_back(m_win);
    for (int i = 0; i < N; i++) begin
      if (EM[i]) begin
        if (irq_in[i] && !m_irq_q[i]) m_pend[i] = 1;
        else if (ack_eff && i == m_win) m_pend[i] = 0;
      end else begin
        m_pend[i] = irq_in[i];
      end
    end
    m_irq_q = irq_in;
    if (ps_ic_mask_wr) m_mask = ps_ic_mask_dt;
    if (!m_req) begin
      pick = -1;
      for (int i = 0; i < N; i++) if (el[i] && pick < 0) pick = i;
      if (pick >= 0) begin
        m_req = 1; m_win = pick; m_vec = 16'(16 + pick * 4);
      end
    end else if (ack_eff || !el[m_win]) begin
      m_req = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("req", ic_ps_req, m_req);
    check("lvl", ic_ps_lvl, m_stk.size());
    check("err", ic_ps_err, m_err);
    check("state", dbg_state, m_req);
    if (m_req) check("vec", ic_ps_vec, m_vec);
  endtask

  task automatic pulse(input int ch);
    irq_in[ch] = 1'b1;
    step();
    irq_in = '0;
  endtask

  task automatic ack_once();
    ps_ic_ack = 1'b1; step(); ps_ic_ack = 1'b0;
  endtask

  task automatic rti_once();
    ps_ic_rti = 1'b1; step(); ps_ic_rti = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; ps_ic_mask_wr = 0; ps_ic_mask_dt = '0;
    ps_ic_ack = 0; ps_ic_rti = 0;
    step(); step();
    check("rst_vec", ic_ps_vec, 16'h0000);
    check("rst_req", ic_ps_req, 0);
    reset = 1'b0;

    // single edge interrupt on ch3
    ps_ic_mask_wr = 1; ps_ic_mask_dt = 8'hFF; step(); ps_ic_mask_wr = 0;
    pulse(3);
    check("t1_req_early", ic_ps_req, 0);
    step();
    check("t1_req", ic_ps_req, 1);
    check("t1_vec", ic_ps_vec, 16'h001C);
    ack_once();
    check("t1_req_ack", ic_ps_req, 0);
    check("t1_lvl", ic_ps_lvl, 1);

    // preemption by ch1 while ch3 in service; ch5 waits
    irq_in[5] = 1; irq_in[1] = 1; step(); irq_in = '0;
    step();
    check("t2_vec", ic_ps_vec, 16'h0014);
    ack_once();
    check("t2_lvl", ic_ps_lvl, 2);
    rti_once(); step();
    check("t2_no_ch5", ic_ps_req, 0);
    rti_once(); step();
    check("t2_ch5_vec", ic_ps_vec, 16'h0024);
    ack_once(); rti_once();

    // level ch2 withdrawn before ack
    irq_in[2] = 1; step(); step();
    check("t3_req", ic_ps_req, 1);
    irq_in[2] = 0; step(); step();
    check("t3_withdrawn", ic_ps_req, 0);
    check("t3_lvl", ic_ps_lvl, 0);

    // full nesting blocks even ch0
    for (int ch = 7; ch >= 4; ch--) begin
      pulse(ch); step(); ack_once();
    end
    check("t4_lvl", ic_ps_lvl, 4);
    pulse(0); step(); step();
    check("t4_blocked", ic_ps_req, 0);
    rti_once(); step();
    check("t4_vec", ic_ps_vec, 16'h0010);
    ack_once();
    for (int k = 0; k < 4; k++) rti_once();

    // error on empty rti; ack+rti together
    rti_once(); step();
    check("t5_err", ic_ps_err, 1);
    pulse(6); step(); ack_once();
    pulse(5); step(); ack_once();
    pulse(3); step();
    ps_ic_ack = 1; ps_ic_rti = 1; step(); ps_ic_ack = 0; ps_ic_rti = 0;
    check("t5_lvl", ic_ps_lvl, 2);
    rti_once(); rti_once();

    // masked edge on ch4 is held until enabled
    ps_ic_mask_wr = 1; ps_ic_mask_dt = 8'hEF; step(); ps_ic_mask_wr = 0;
    pulse(4); step(); step();
    check("t6_masked", ic_ps_req, 0);
    ps_ic_mask_wr = 1; ps_ic_mask_dt = 8'hFF; step(); ps_ic_mask_wr = 0;
    step();
    check("t6_vec", ic_ps_vec, 16'h0020);
    ack_once(); rti_once();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      irq_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ps_ic_ack = ($urandom_range(0, 2) == 0);
      ps_ic_rti = ($urandom_range(0, 4) == 0);
      ps_ic_mask_wr = ($urandom_range(0, 15) == 0);
      ps_ic_mask_dt = 8'($urandom) | 8'($urandom);
      step();
    end
    irq_in = '0; ps_ic_ack = 0; ps_ic_rti = 0; ps_ic_mask_wr = 0;

    // reset in the middle of a request
    ps_ic_mask_wr = 1; ps_ic_mask_dt = 8'hFF; step(); ps_ic_mask_wr = 0;
    pulse(1); step();
    check("t7_req", ic_ps_req, 1);
    reset = 1; step(); reset = 0;
    check("t7_req_rst", ic_ps_req, 0);
    check("t7_vec_rst", ic_ps_vec, 16'h0000);
    check("t7_lvl_rst", ic_ps_lvl, 0);
    step(); step();
    check("t7_idle", ic_ps_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
